// File: rtl/xdt_dy_dct.sv
// 8x8 2-D DCT: row pass (XDT) feeding an in-place column accumulator (DY), drained one column per cycle.
// Define DCT_ROUND_EN to round half-up before each >>>7; otherwise both passes floor.
package xdt_dy_dct_pkg;
  // Scale-128 cosine table, one 64-bit word per frequency row, j=0 in the top byte.
  function automatic logic signed [7:0] coef(input logic [2:0] k, input logic [2:0] j);
    logic [63:0] row;
    case (k)
      3'd0:    row = 64'h2D2D2D2D_2D2D2D2D;
      3'd1:    row = 64'h3F35240C_F4DCCBC1;
      3'd2:    row = 64'h3B18E8C5_C5E8183B;
      3'd3:    row = 64'h35F4C1DC_243F0CCB;
      3'd4:    row = 64'h2DD3D32D_2DD3D32D;
      3'd5:    row = 64'h24C10C35_CBF43FDC;
      3'd6:    row = 64'h18C53BE8_E83BC518;
      default: row = 64'h0CDC35C1_3FCB24F4;
    endcase
    return $signed(row[{~j, 3'b000} +: 8]);
  endfunction
endpackage

// One frequency lane v: row accumulator acc_v, output y_v, and block column bacc[0..7][v].
module xdt_dy_dct_lane
  import xdt_dy_dct_pkg::*;
#(
  parameter logic [2:0] V  = 3'd0,
  parameter int         N  = 8,
  parameter int         RW = 12,
  parameter int         CW = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N-1:0]         xin,
  input  logic [2:0]           j,
  input  logic [2:0]           r,
  input  logic                 row_done,
  output logic signed [RW-1:0] y,
  output logic [7:0][CW-1:0]   f
);
  localparam int AW = 20;
  localparam int BW = 24;
`ifdef DCT_ROUND_EN
  localparam int RND = 64;
`else
  localparam int RND = 0;
`endif

  logic signed [AW-1:0] acc, px, cx, rsum, rsh;
  logic signed [BW-1:0] bacc [8];
  logic signed [BW-1:0] bsum [8];
  logic signed [BW-1:0] bsh  [8];

  assign px   = AW'({1'b0, xin});
  assign cx   = AW'(coef(V, j));
  assign rsum = acc + px * cx;
  assign rsh  = (rsum + AW'(RND)) >>> 7;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      y   <= '0;
    end else if (start) begin
      if (j == 3'd7) begin
        acc <= '0;
        y   <= RW'(rsh);
      end else begin
        acc <= rsum;
      end
    end
  end

  always_comb begin
    for (int u = 0; u < 8; u++) begin
      bsum[u] = bacc[u] + BW'(coef(3'(u), r)) * BW'(y);
      bsh[u]  = (bsum[u] + BW'(RND)) >>> 7;
    end
  end

  // Row 7 closes the block: scaled sums go to the output buffer, accumulators restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < 8; u++) bacc[u] <= '0;
      f <= '0;
    end else if (row_done) begin
      for (int u = 0; u < 8; u++) begin
        if (r == 3'd7) begin
          bacc[u] <= '0;
          f[u]    <= CW'(bsh[u]);
        end else begin
          bacc[u] <= bsum[u];
        end
      end
    end
  end
endmodule

module xdt_dy_dct #(
  parameter int N  = 8,
  parameter int RW = 2*N - 4,
  parameter int CW = 4*N - 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N-1:0]         xin,
  output logic                 row_done,
  output logic signed [RW-1:0] y0, y1, y2, y3, y4, y5, y6, y7,
  output logic                 col_valid,
  output logic signed [CW-1:0] z0, z1, z2, z3, z4, z5, z6, z7
);
  logic [2:0]                j, r, m;
  logic                      load_q;
  logic [7:0][RW-1:0]        yv;
  logic [7:0][7:0][CW-1:0]   fb;   // [v][u]
  logic [7:0][CW-1:0]        zr;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    xdt_dy_dct_lane #(.V(3'(g)), .N(N), .RW(RW), .CW(CW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .xin      (xin),
      .j        (j),
      .r        (r),
      .row_done (row_done),
      .y        (yv[g]),
      .f        (fb[g])
    );
  end

  // Output column m is lane m's buffer, so a whole lane vector becomes z0..z7.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j         <= '0;
      r         <= '0;
      m         <= '0;
      row_done  <= 1'b0;
      load_q    <= 1'b0;
      col_valid <= 1'b0;
      zr        <= '0;
    end else begin
      row_done <= start && (j == 3'd7);
      load_q   <= row_done && (r == 3'd7);
      if (start)    j <= j + 3'd1;
      if (row_done) r <= r + 3'd1;
      if (load_q) begin
        col_valid <= 1'b1;
        m         <= '0;
        zr        <= fb[0];
      end else if (col_valid) begin
        if (m == 3'd7) begin
          col_valid <= 1'b0;
        end else begin
          m  <= m + 3'd1;
          zr <= fb[m + 3'd1];
        end
      end
    end
  end

  assign {y7, y6, y5, y4, y3, y2, y1, y0} = yv;
  assign {z7, z6, z5, z4, z3, z2, z1, z0} = zr;
endmodule

// File: tb/tb_xdt_dy_dct.sv
// Scoreboard bench for xdt_dy_dct: stimulus pushes expected rows/columns, a monitor pops on row_done/col_valid.
module tb_xdt_dy_dct;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] xin = '0;
  logic row_done, col_valid;
  logic signed [11:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic signed [19:0] z0, z1, z2, z3, z4, z5, z6, z7;

  typedef logic [7:0][11:0] yv_t;
  typedef logic [7:0][19:0] zv_t;
  yv_t ya, yq[$];
  zv_t za, zq[$];
  int n_chk = 0, n_fail = 0;
  bit sb_on = 1'b0;
  logic [7:0] pix [64];

`ifdef DCT_ROUND_EN
  localparam int RND = 64;
`else
  localparam int RND = 0;
`endif

  int ct [8][8] = '{
    '{45, 45, 45, 45, 45, 45, 45, 45},
    '{63, 53, 36, 12, -12, -36, -53, -63},
    '{59, 24, -24, -59, -59, -24, 24, 59},
    '{53, -12, -63, -36, 36, 63, 12, -53},
    '{45, -45, -45, 45, 45, -45, -45, 45},
    '{36, -63, 12, 53, -53, -12, 63, -36},
    '{24, -59, 59, -24, -24, 59, -59, 24},
    '{12, -36, 53, -63, 63, -53, 36, -12}};

  xdt_dy_dct dut (
    .clk(clk), .reset(reset), .start(start), .xin(xin), .row_done(row_done),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .col_valid(col_valid),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7));

  always #5 clk = ~clk;
  assign ya = {y7, y6, y5, y4, y3, y2, y1, y0};
  assign za = {z7, z6, z5, z4, z3, z2, z1, z0};

  function automatic void chk(string name, logic [159:0] act, logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    yv_t ey;
    zv_t ez;
    if (sb_on && row_done) begin
      if (yq.size() == 0) chk("row_unexpected", 160'(1), 160'(0));
      else begin ey = yq.pop_front(); chk("row_y", 160'(ya), 160'(ey)); end
    end
    if (sb_on && col_valid) begin
      if (zq.size() == 0) chk("col_unexpected", 160'(1), 160'(0));
      else begin ez = zq.pop_front(); chk("col_z", 160'(za), 160'(ez)); end
    end
  end

  // Blocks whose only non-zero terms are y0 and z0 at column 0.
  task automatic push_flat(input int y0v, input int z0v);
    yv_t t;
    zv_t c;
    t = '0; t[0] = 12'(y0v);
    for (int i = 0; i < 8; i++) yq.push_back(t);
    c = '0; c[0] = 20'(z0v);
    zq.push_back(c);
    for (int i = 1; i < 8; i++) zq.push_back('0);
  endtask

  task automatic push_model();
    int s;
    int yy [8][8];
    yv_t t;
    zv_t c;
    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < 8; v++) begin
        s = 0;
        for (int j = 0; j < 8; j++) s += int'(pix[r*8+j]) * ct[v][j];
        yy[r][v] = (s + RND) >>> 7;
        t[v] = 12'(yy[r][v]);
      end
      yq.push_back(t);
    end
    for (int mm = 0; mm < 8; mm++) begin
      for (int u = 0; u < 8; u++) begin
        s = 0;
        for (int r = 0; r < 8; r++) s += ct[u][r] * yy[r][mm];
        c[u] = 20'((s + RND) >>> 7);
      end
      zq.push_back(c);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 64; i++)
      case (mode)
        0: pix[i] = 8'd128;
        1: pix[i] = (i == 0) ? 8'd255 : 8'd0;
        2: pix[i] = 8'd0;
        3: pix[i] = 8'd255;
        default: pix[i] = 8'((i * 37 + (i / 8) * 11) % 256);
      endcase
  endtask

  task automatic drive(input bit pause);
    for (int i = 0; i < 64; i++) begin
      if (pause) begin start = 1'b0; xin = 8'hAA; @(posedge clk); #1; end
      start = 1'b1; xin = pix[i];
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (yq.size() != 0 || zq.size() != 0); k++) @(posedge clk);
    chk("drain_rows_left", 160'(yq.size()), 160'(0));
    chk("drain_cols_left", 160'(zq.size()), 160'(0));
    yq.delete(); zq.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string name);
    chk({name, "_row_done"}, 160'(row_done), 160'(0));
    chk({name, "_col_valid"}, 160'(col_valid), 160'(0));
    chk({name, "_y"}, 160'(ya), 160'(0));
    chk({name, "_z"}, 160'(za), 160'(0));
  endtask

  initial begin
    #2 chk_zero("reset_init");
    @(posedge clk); #1 reset = 1'b1;
    // One full row plus a partial row, then an asynchronous reset mid-row.
    for (int i = 0; i < 13; i++) begin
      start = 1'b1; xin = 8'd200; @(posedge clk); #1;
    end
    start = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("reset_mid");
    @(posedge clk); #1 reset = 1'b1; sb_on = 1'b1;

    fill(0); push_flat(360, (RND != 0) ? 1013 : 1012); drive(1'b0); drain();
    fill(1); push_model(); drive(1'b0); drain();
    fill(0); push_flat(360, (RND != 0) ? 1013 : 1012); drive(1'b1); drain();
    // Back-to-back: constant 128 immediately followed by an all-zero block.
    push_flat(360, (RND != 0) ? 1013 : 1012); push_flat(0, 0);
    fill(0); drive(1'b0); fill(2); drive(1'b0); drain();
    fill(3); push_flat(717, (RND != 0) ? 2017 : 2016); drive(1'b0); drain();
    fill(4); push_model(); drive(1'b0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xdt_dy_dct.md
Name: xdt_dy_dct

Overview:
- 8x8 two-dimensional DCT engine for the JPEG compressor datapath.
- Accepts a raster-ordered stream of 8-bit pixels, one per clock.
- First (row) pass, XDT: produces the 1-D DCT of each 8-pixel row.
- Second (column) pass, DY: accumulates the row results into the full 8x8 coefficient block and streams it out one column per cycle. Feeds the quantiser.

Parameters:
- N, 8: pixel width. Only N=8 is required.
- Derived widths: row result RW = 2N-4 (12); block result CW = 4N-12 (20).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pixel-valid; xin is consumed on every rising edge where start=1
- xin  in  N  unsigned pixel, raster order (row-major, 64 per block)
- row_done  out  1  one-cycle pulse: y0..y7 hold a new row result
- y0..y7  out  RW each  signed row-pass result, index = frequency v
- col_valid  out  1  high for 8 consecutive cycles per finished block
- z0..z7  out  CW each  signed block coefficients for the current output column, index = u

Behaviour:
- Coefficient ROM is internal and signed 8-bit, C[k][j] (row k, column j), scale 128:
  - k0: 45 45 45 45 45 45 45 45
  - k1: 63 53 36 12 -12 -36 -53 -63
  - k2: 59 24 -24 -59 -59 -24 24 59
  - k3: 53 -12 -63 -36 36 63 12 -53
  - k4: 45 -45 -45 45 45 -45 -45 45
  - k5: 36 -63 12 53 -53 -12 63 -36
  - k6: 24 -59 59 -24 -24 59 -59 24
  - k7: 12 -36 53 -63 63 -53 36 -12
- Reset (asynchronous, while reset=0): clear every counter and accumulator; row_done=0, col_valid=0, y*=0, z*=0.
- Row pass (XDT):
  - 3-bit column counter j advances on every accepted pixel and wraps 7->0.
  - Each accepted pixel: acc_v += xin * C[v][j] for all v; xin is zero-extended.
  - Accumulators are at least 19-bit signed.
  - On the edge that accepts j=7:
    - y_v <= (acc_v + xin*C[v][7]) >>> 7, arithmetic shift, truncated to RW bits;
    - row_done <= 1 for exactly one cycle;
    - accumulators restart from 0 for the next row.
  - y_v holds its value until the next row completes.
- Column pass (DY):
  - 3-bit row counter r increments on each row_done and wraps 7->0.
  - On the cycle row_done=1: bacc[u][v] += C[u][r] * y_v for all 64 (u,v).
  - Accumulators are at least 23-bit signed.
  - When the r=7 row is added:
    - F[u][v] = bacc >>> 7, sign-extended to CW;
    - F is copied into a 64-entry output buffer;
    - bacc is cleared.
- Output:
  - The cycle after the buffer load, col_valid=1 for 8 cycles.
  - Output cycle m (0..7) presents z_u = F[u][m].
  - z* hold their last value when col_valid=0.
- Pause: start=0 freezes j, r and all accumulators; a row or block may span gaps.
- Back-to-back blocks are legal. The next block takes at least 64 cycles to finish, so the 8-cycle drain never overlaps a buffer load. No backpressure.
- Reset mid-block discards the partial row and the partial block.

Optional Feature:
- Macro: DCT_ROUND_EN.
- Defined: add 64 before each >>>7, in both passes (round-half-up).
- Undefined: plain arithmetic shift (floor).

Test Plan:
- Reset asserted mid-row, then released → all outputs 0; the first pixel after release is treated as j=0, r=0.
- Constant block, 64 pixels all 128, start held high:
  - every row_done shows y0=360, y1..y7=0;
  - col_valid cycle 0 shows z0=1012 (1013 with DCT_ROUND_EN), z1..z7=0;
  - col_valid cycles 1..7 show all z=0.
- Impulse block, pixel[0][0]=255, others 0:
  - first row_done shows y0=89, y1=125;
  - col_valid cycle 0 shows z0=31.
- Pause test: start toggled every other cycle during the constant-128 block → identical results; row_done still fires once per 8 accepted pixels.
- Two consecutive blocks (constant 128, then all 0):
  - second block's col_valid burst has all z=0;
  - first burst is uncorrupted.
- Full-scale block, all 255 → z0 at cycle 0 = 2016 (floor) with no overflow; all other coefficients 0.
